ad9958_spi_master: RTL
======================

Name: ad9958_spi_master

Overview:
Serial back-end for the AD9958 controller. It consumes the one-shot write requests issued by ad9958_core: trigger, packs_to_send and data_input. It serializes each request MSB-first onto the AD9958 serial port (CS_N, SCLK, SDIO_0..3) in either single-bit or 4-bit (quad) lane mode. It reports busy back to the core for the whole transfer, including the CS recovery gap.

Parameters:
CLK_DIV, 2, system clocks per SCLK half-period (legal range 1..255).
CS_GAP, 2, system clocks that cs_n is held high after a transfer before busy drops (legal range 1..255).
MAX_PACKS, 16, largest legal packs_to_send value (one pack = 4 bits, so 16 packs = the 64-bit data_input).

Ports:
clock  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
trigger  in  1  one-cycle start request from the core.
packs_to_send  in  5  number of 4-bit packs to send.
data_input  in  64  payload, right-aligned.
quad_mode  in  1  lane mode: 1 = 4-bit lane mode, 0 = single-bit on SDIO_0; sampled at trigger.
busy  out  1  transfer in progress.
cs_n  out  1  AD9958 chip select.
sclk  out  1  AD9958 serial clock.
sdio  out  4  AD9958 SDIO_3..0.
sdio_oe  out  1  pad output enable.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: cs_n=1, sclk=0, sdio=0, sdio_oe=0, state=IDLE, all counters 0. Reset mid-transfer aborts immediately; no partial-frame recovery is attempted.
- busy is combinational: busy = (state != IDLE) | (trigger & packs_to_send != 0).
  - The core samples busy one cycle after pulsing trigger, so busy must already be high then.
  - busy stays high until the GAP state completes.
- Capture at trigger (state IDLE only):
  - Latch data_input, the effective pack count and quad_mode.
  - Effective pack count: packs_to_send clamped to MAX_PACKS.
  - packs_to_send=0: no transfer; state stays IDLE and busy stays 0.
  - trigger while not IDLE: ignored, with no effect on the transfer in flight.
- Bit order and lanes:
  - The first pack sent is data_input[4*N-1 -: 4] (N = effective packs); then descending.
  - Quad mode: one SCLK per pack, sdio[3:0] = pack bits[3:0].
  - Single mode: four SCLKs per pack, MSB first on sdio[0], sdio[3:1]=0.
  - Slots S = N (quad) or 4N (single).
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - SETUP: cs_n=0, sdio_oe=1, first slot's data driven, sclk=0, for CLK_DIV clocks.
  - SHIFT: sclk toggles every CLK_DIV clocks.
    - The device samples on the rising edge.
    - sdio updates only coincident with sclk falling edges, so data is stable for a full period around each rising edge.
    - After the S-th rising edge and the following low half-period, go to HOLD. sclk ends low.
  - HOLD: cs_n stays 0 for CLK_DIV clocks, then cs_n=1, sdio_oe=0, sdio=0.
  - GAP: CS_GAP clocks with cs_n=1, then IDLE.
- Latency: trigger to cs_n falling is 1 clock.
  - Total busy duration = 1 + CLK_DIV*(2 + 2S) + CS_GAP clocks.
- Counters:
  - Half-period counter of width 8, with wrap to 0 at CLK_DIV-1.
  - Slot counter of width 7 (max 64), decrements per rising edge; SHIFT exits at 0.
  - Shift register of 64 bits, left-shifted by 4 (quad) or 1 (single); the output slice is indexed from the captured N.
- quad_mode changes mid-transfer have no effect on the transfer in flight.

Decomposition:
- Shared package: add to ad9958_vars.vh the defines LANE_SINGLE / LANE_QUAD and PACK_BITS=4. SIZE_* already lives in ad9958_registers.vh and is reused as-is.
- One sub-module: ad9958_sclk_gen.
  - Input: enable. Outputs: rise_tick, fall_tick, sclk. Parameter: CLK_DIV.
  - Clears to sclk=0 whenever enable=0.

Test Plan:
- Quad, CLK_DIV=2, packs=2, data=0x...0043 (CSR instruction write 0x00 is also checked) -> exactly 2 SCLK rising edges sampling sdio=0x4 then 0x3; busy high 1+2*(2+4)+2=15 clocks.
- Single, CLK_DIV=1, packs=2, data=0xA5 -> 8 rising edges with sdio[0] sampling 1,0,1,0,0,1,0,1; sdio[3:1]=0 throughout.
- Quad, packs=16, data=0x0123456789ABCDEF -> packs 0..F in order; packs_to_send=20 gives identical traffic (clamp).
- packs_to_send=0 with trigger -> cs_n never falls, busy stays 0; a second trigger mid-transfer -> ignored, first frame bit-exact.
- reset_n asserted low mid-SHIFT -> cs_n=1, sclk=0, busy=0 asynchronously; the next trigger after release runs a clean full frame.
- Core-in-loop: ad9958_core plus this block -> init sequence then repeated CSR/CFTW0/ACR frames for ch0 and ch1, each decoded by an AD9958 serial-port model with matching address and data values.

Source files
------------

// File: rtl/ad9958_spi_master_pkg.sv
// Shared types and constants for the AD9958 serial-port back-end.
`timescale 1ns/1ps
package ad9958_spi_master_pkg;

    localparam int DATA_W    = 64;
    localparam int SLOT_W    = 7;
    localparam int HALF_W    = 8;
    localparam int PACK_BITS = 4;

    localparam logic LANE_SINGLE = 1'b0;
    localparam logic LANE_QUAD   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Slot presented on SDIO_3..0 from a left-aligned shift register.
    function automatic logic [3:0] lane_slice(input logic [DATA_W-1:0] v, input logic quad);
        return (quad == LANE_QUAD) ? v[DATA_W-1 -: PACK_BITS] : {3'b000, v[DATA_W-1]};
    endfunction

endpackage

// File: rtl/ad9958_sclk_gen.sv
// SCLK generator: half-period counter with rise/fall ticks one clock ahead of the sclk edge.
`timescale 1ns/1ps
module ad9958_sclk_gen
    import ad9958_spi_master_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    logic [HALF_W-1:0] r_cnt;
    logic              r_sclk;
    logic              w_wrap;

    // Ticks depend only on registered state so the parent may gate enable with them.
    assign w_wrap    = (r_cnt == HALF_W'(CLK_DIV - 1));
    assign rise_tick = w_wrap & ~r_sclk;
    assign fall_tick = w_wrap &  r_sclk;
    assign sclk      = r_sclk;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!enable) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ad9958_spi_master.sv
// AD9958 serial-port master: serializes one-shot core writes MSB-first in single or quad lane mode.
`timescale 1ns/1ps
module ad9958_spi_master
    import ad9958_spi_master_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int CS_GAP    = 2,
    parameter int MAX_PACKS = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              trigger,
    input  logic [4:0]        packs_to_send,
    input  logic [DATA_W-1:0] data_input,
    input  logic              quad_mode,
    output logic              busy,
    output logic              cs_n,
    output logic              sclk,
    output logic [3:0]        sdio,
    output logic              sdio_oe
);

    state_t              r_state, n_state;
    logic [SLOT_W-1:0]   r_slots, n_slots;
    logic [DATA_W-1:0]   r_shreg, n_shreg;
    logic                r_quad, n_quad;
    logic [HALF_W-1:0]   r_cnt, n_cnt;
    logic                r_cs_n, n_cs_n;
    logic                r_oe, n_oe;
    logic [3:0]          r_sdio, n_sdio;

    logic [4:0]          w_packs;
    logic [SLOT_W-1:0]   w_slots;
    logic [DATA_W-1:0]   w_aligned;
    logic                w_gen_en;
    logic                w_rise;
    logic                w_fall;

    assign w_packs   = (packs_to_send > 5'(MAX_PACKS)) ? 5'(MAX_PACKS) : packs_to_send;
    assign w_slots   = (quad_mode == LANE_QUAD) ? {2'b00, w_packs} : {w_packs, 2'b00};
    // Left-align the payload so the first pack always sits in the top nibble.
    assign w_aligned = data_input << (7'd64 - {w_packs, 2'b00});

    assign busy    = (r_state != ST_IDLE) | (trigger & (packs_to_send != 5'd0));
    assign cs_n    = r_cs_n;
    assign sdio    = r_sdio;
    assign sdio_oe = r_oe;

    // Dropping enable on the terminating rise tick keeps sclk low instead of starting an extra slot.
    assign w_gen_en = (r_state == ST_SETUP) |
                      ((r_state == ST_SHIFT) & ~(w_rise & (r_slots == 7'd0)));

    ad9958_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (w_gen_en),
        .rise_tick (w_rise),
        .fall_tick (w_fall),
        .sclk      (sclk)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_slots <= '0;
            r_shreg <= '0;
            r_quad  <= LANE_SINGLE;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_oe    <= 1'b0;
            r_sdio  <= '0;
        end else begin
            r_state <= n_state;
            r_slots <= n_slots;
            r_shreg <= n_shreg;
            r_quad  <= n_quad;
            r_cnt   <= n_cnt;
            r_cs_n  <= n_cs_n;
            r_oe    <= n_oe;
            r_sdio  <= n_sdio;
        end
    end

    // NOTE: every next-state variable is defaulted first so no path can infer a latch.
    always_comb begin
        n_state = r_state;
        n_slots = r_slots;
        n_shreg = r_shreg;
        n_quad  = r_quad;
        n_cnt   = r_cnt;
        n_cs_n  = r_cs_n;
        n_oe    = r_oe;
        n_sdio  = r_sdio;

        unique case (r_state)
            ST_IDLE: begin
                if (trigger && (w_packs != 5'd0)) begin
                    n_state = ST_SETUP;
                    n_slots = w_slots;
                    n_shreg = w_aligned;
                    n_quad  = quad_mode;
                    n_cnt   = '0;
                    n_cs_n  = 1'b0;
                    n_oe    = 1'b1;
                    n_sdio  = lane_slice(w_aligned, quad_mode);
                end
            end
            ST_SETUP: begin
                if (w_rise) begin
                    n_state = ST_SHIFT;
                    n_slots = r_slots - 7'd1;
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    if (r_slots == 7'd0) n_state = ST_HOLD;
                    else                 n_slots = r_slots - 7'd1;
                end
                // Data only advances on falling edges, and only while slots remain.
                if (w_fall && (r_slots != 7'd0)) begin
                    n_shreg = (r_quad == LANE_QUAD) ? (r_shreg << PACK_BITS) : (r_shreg << 1);
                    n_sdio  = lane_slice(n_shreg, r_quad);
                end
            end
            ST_HOLD: begin
                if (r_cnt == HALF_W'(CLK_DIV - 1)) begin
                    n_state = ST_GAP;
                    n_cnt   = '0;
                    n_cs_n  = 1'b1;
                    n_oe    = 1'b0;
                    n_sdio  = '0;
                end else begin
                    n_cnt = r_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == HALF_W'(CS_GAP - 1)) begin
                    n_state = ST_IDLE;
                    n_cnt   = '0;
                end else begin
                    n_cnt = r_cnt + 8'd1;
                end
            end
            default: n_state = ST_IDLE;
        endcase
    end

endmodule
